// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix responder: FSM encoding, key code fields, idle column level.
// Pure declarations; no logic, no latency, no flow control.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAKE_B = 3'd1,
        ST_HOLD   = 3'd2,
        ST_BRK_B  = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam int KEY_ROW_HI = 3;
    localparam int KEY_ROW_LO = 2;
    localparam int KEY_COL_HI = 1;
    localparam int KEY_COL_LO = 0;

    // Columns are active-low, so an untouched matrix reads all ones.
    localparam logic [3:0] COL_IDLE = 4'hF;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[KEY_ROW_HI:KEY_ROW_LO];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[KEY_COL_HI:KEY_COL_LO];
    endfunction

endpackage

// File: rtl/keypad_matrix_responder_if.sv
// Press-command port of the keypad responder: valid/ready handshake carrying key code and hold length.
// No storage; ready is owned by the responder side.
interface keypad_matrix_responder_if #(
    parameter int CNT_W = 16
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_key;
    logic [CNT_W-1:0] cmd_hold;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        output cmd_ready
    );

endinterface

// File: rtl/keypad_col_drive.sv
// Registered column encoder: pulls the latched column low while the contact is closed and its row is driven.
// One cycle latency from keypadRow/contact to keypadCol; no backpressure.
module keypad_col_drive
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       contact,
    input  logic [1:0] row,
    input  logic [1:0] col,
    input  logic [3:0] keypadRow,
    output logic [3:0] keypadCol
);

    logic [3:0] col_nxt;

    // Only the latched row matters, so several driven rows behave like one.
    always_comb begin
        col_nxt = COL_IDLE;
        if (contact && !keypadRow[row]) begin
            col_nxt[col] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keypadCol <= COL_IDLE;
        end else begin
            keypadCol <= col_nxt;
        end
    end

endmodule

// File: rtl/keypad_matrix_responder.sv
// Keypad matrix responder: plays one pressed key (with make/break bounce) against a row-scanning keypad reader.
// Column response lags keypadRow by one cycle; commands are accepted only in IDLE and never queued.
module keypad_matrix_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_CYC   = 1000,
    parameter int BOUNCE_CYC = 64,
    parameter int BOUNCE_TGL = 8,
    parameter int GAP_CYC    = 500,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                keypadRow,
    output logic [3:0]                keypadCol,
    keypad_matrix_responder_if.slave  cmd,
    output logic                      busy,
    output logic                      done
);

    // A zero-length window still occupies one cycle so the state sequence stays fixed.
    localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TGL_LAST = CNT_W'((BOUNCE_TGL > 0) ? BOUNCE_TGL - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_DEF = CNT_W'(HOLD_CYC);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tgl_cnt;
    logic             tgl;
    logic [3:0]       key_q;
    logic [CNT_W-1:0] hold_len_q;
    logic             contact;
    logic             accept;
    logic             phase_end;

    // Holding ready low during the done cycle keeps accept and done apart.
    assign cmd.cmd_ready = (state == ST_IDLE) && !done;
    assign busy          = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        contact   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_MAKE_B;
                end
            end
            ST_MAKE_B: begin
                contact = !tgl;
                if (cnt == BNC_LAST) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                contact = 1'b1;
                if (cnt == hold_len_q - CNT_W'(1)) begin
                    state_nxt = ST_BRK_B;
                end
            end
            ST_BRK_B: begin
                contact = tgl;
                if (cnt == BNC_LAST) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        phase_end = (state_nxt != state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tgl_cnt    <= '0;
            tgl        <= 1'b0;
            done       <= 1'b0;
            key_q      <= 4'h0;
            hold_len_q <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_GAP) && (state_nxt == ST_IDLE);
            if (phase_end) begin
                cnt     <= '0;
                tgl_cnt <= '0;
                tgl     <= 1'b0;
            end else if (state != ST_IDLE) begin
                cnt <= cnt + CNT_W'(1);
                if (tgl_cnt == TGL_LAST) begin
                    tgl_cnt <= '0;
                    tgl     <= !tgl;
                end else begin
                    tgl_cnt <= tgl_cnt + CNT_W'(1);
                end
            end
            if (accept) begin
                key_q      <= cmd.cmd_key;
                hold_len_q <= (cmd.cmd_hold == '0) ? HOLD_DEF : cmd.cmd_hold;
            end
        end
    end

    keypad_col_drive u_col_drive (
        .clk       (clk),
        .rst       (rst),
        .contact   (contact),
        .row       (key_row(key_q)),
        .col       (key_col(key_q)),
        .keypadRow (keypadRow),
        .keypadCol (keypadCol)
    );

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Bench for keypad_matrix_responder: two parameterisations driven identically, checked against a timeline model.
module tb_keypad_matrix_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic        valid;
    logic [3:0]  key;
    logic [15:0] hold;

    logic [3:0]  col_a, col_b;
    logic        busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keypad_matrix_responder_if #(.CNT_W(16)) ifa ();
    keypad_matrix_responder_if #(.CNT_W(16)) ifb ();

    assign ifa.cmd_valid = valid;
    assign ifa.cmd_key   = key;
    assign ifa.cmd_hold  = hold;
    assign ifb.cmd_valid = valid;
    assign ifb.cmd_key   = key;
    assign ifb.cmd_hold  = hold;

    keypad_matrix_responder #(
        .HOLD_CYC(40), .BOUNCE_CYC(16), .BOUNCE_TGL(4), .GAP_CYC(20), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .keypadRow(row_in), .keypadCol(col_a),
        .cmd(ifa.slave), .busy(busy_a), .done(done_a)
    );

    keypad_matrix_responder #(
        .HOLD_CYC(30), .BOUNCE_CYC(0), .BOUNCE_TGL(8), .GAP_CYC(10), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .keypadRow(row_in), .keypadCol(col_b),
        .cmd(ifb.slave), .busy(busy_b), .done(done_b)
    );

    // Model parameters; a zero bounce window is modelled as its one-cycle effective length.
    int p_bnc [2] = '{16, 1};
    int p_tgl [2] = '{4, 8};
    int p_hold[2] = '{40, 30};
    int p_gap [2] = '{20, 10};

    // t = cycles since the accepting edge (0 = idle); the whole press is derived from t.
    int         m_t   [2];
    bit         m_done[2];
    logic [3:0] m_key [2];
    int         m_hold[2];
    logic [3:0] m_col [2];

    int  fall_cnt, rise_cnt, done_cnt;
    logic prev_bit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit contact_at(int d, int t);
        int b = p_bnc[d];
        int h = m_hold[d];
        if (t < 1) return 1'b0;
        if (t <= b) return (((t - 1) / p_tgl[d]) % 2) == 0;
        if (t <= b + h) return 1'b1;
        if (t <= 2 * b + h) return (((t - b - h - 1) / p_tgl[d]) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic model_step(input int d);
        logic [1:0] r, c;
        if (rst) begin
            m_t[d]    = 0;
            m_done[d] = 1'b0;
            m_col[d]  = 4'hF;
        end else begin
            r = m_key[d][3:2];
            c = m_key[d][1:0];
            m_col[d] = 4'hF;
            if (contact_at(d, m_t[d]) && !row_in[r]) m_col[d][c] = 1'b0;
            if (m_t[d] == 0) begin
                if (!m_done[d] && valid) begin
                    m_t[d]    = 1;
                    m_key[d]  = key;
                    m_hold[d] = (hold == 16'd0) ? p_hold[d] : int'(hold);
                end
                m_done[d] = 1'b0;
            end else if (m_t[d] == 2 * p_bnc[d] + m_hold[d] + p_gap[d]) begin
                m_t[d]    = 0;
                m_done[d] = 1'b1;
            end else begin
                m_t[d] = m_t[d] + 1;
            end
        end
    endtask

    task automatic cmp_dut(input int d, input logic [3:0] col, input logic bsy,
                           input logic dn, input logic rdy);
        chk($sformatf("col%0d", d),   32'(col), 32'(m_col[d]));
        chk($sformatf("busy%0d", d),  32'(bsy), 32'(m_t[d] != 0));
        chk($sformatf("done%0d", d),  32'(dn),  32'(m_done[d]));
        chk($sformatf("ready%0d", d), 32'(rdy), 32'(m_t[d] == 0 && !m_done[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cmp_dut(0, col_a, busy_a, done_a, ifa.cmd_ready);
        cmp_dut(1, col_b, busy_b, done_b, ifb.cmd_ready);
        if (prev_bit && !col_a[2]) fall_cnt++;
        if (!prev_bit && col_a[2]) rise_cnt++;
        prev_bit = col_a[2];
        if (done_a) done_cnt++;
    endtask

    // Issues one command and returns the tick (accept tick = 1) on which done_a is seen.
    task automatic press(input logic [3:0] k, input logic [15:0] h, output int n);
        valid = 1'b1;
        key   = k;
        hold  = h;
        tick();
        valid = 1'b0;
        n = 1;
        while (!done_a && n < 400) begin
            tick();
            n++;
        end
        tick();
    endtask

    initial begin
        int n, k;
        for (int d = 0; d < 2; d++) begin
            m_t[d] = 0; m_done[d] = 1'b0; m_key[d] = 4'h0; m_hold[d] = 0; m_col[d] = 4'hF;
        end
        fall_cnt = 0; rise_cnt = 0; done_cnt = 0; prev_bit = 1'b1;
        rst = 1'b1; row_in = 4'b1110; valid = 1'b0; key = 4'h0; hold = 16'd0;

        // Reset held with a row driven: outputs stay idle.
        for (int i = 0; i < 10; i++) tick();
        chk("rst_col", 32'(col_a), 32'hF);
        rst = 1'b0;
        tick();

        // Key 6 on the zero-bounce instance: column 2 answers only while row 1 is driven.
        row_in = 4'b1101;
        valid = 1'b1; key = 4'h6; hold = 16'd20;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("hold_col_b", 32'(col_b), 32'b1011);
        row_in = 4'b1110;
        tick();
        chk("other_row_col_b", 32'(col_b), 32'hF);
        row_in = 4'b1101;
        n = 1;
        while (!done_a && n < 400) begin tick(); n++; end
        tick();

        // Bounce shape and accept-to-done latency with an explicit hold.
        fall_cnt = 0; rise_cnt = 0; done_cnt = 0;
        press(4'h6, 16'd20, n);
        chk("make_edges", 32'(fall_cnt), 32'd5);
        chk("break_edges", 32'(rise_cnt), 32'd5);
        chk("lat_hold20", 32'(n), 32'(2 * 16 + 20 + 20 + 1));
        chk("done_once", 32'(done_cnt), 32'd1);

        // cmd_hold = 0 falls back to the default hold length.
        press(4'hB, 16'd0, n);
        chk("lat_hold0", 32'(n), 32'(2 * 16 + 40 + 20 + 1));

        // Valid held across a press: the second key waits until after done.
        valid = 1'b1; key = 4'h6; hold = 16'd0;
        tick();
        key = 4'h9; hold = 16'd5;
        n = 1;
        while (!done_a && n < 400) begin tick(); n++; end
        chk("held_valid_lat", 32'(n), 32'(2 * 16 + 40 + 20 + 1));
        tick();
        chk("no_accept_on_done", 32'(busy_a), 32'd0);
        tick();
        chk("accept_after_done", 32'(busy_a), 32'd1);
        valid = 1'b0;
        for (int i = 0; i < 200; i++) tick();

        // Reset in the middle of HOLD: immediate release, no completion.
        press(4'h0, 16'd0, n);
        valid = 1'b1; key = 4'h6; hold = 16'd50;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 26; i++) tick();
        chk("pre_rst_col", 32'(col_a), 32'b1011);
        rst = 1'b1;
        tick();
        chk("rst_mid_col", 32'(col_a), 32'hF);
        chk("rst_mid_ready", 32'(ifa.cmd_ready), 32'd1);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 150; i++) tick();
        chk("no_done_after_rst", 32'(done_cnt), 32'd0);

        // Random traffic, rows and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            k = $urandom_range(0, 3);
            if (k == 0) row_in = 4'hF;
            else if (k == 1) row_in = ~(4'b0001 << $urandom_range(0, 3));
            else row_in = 4'($urandom);
            valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) key = 4'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
